// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and async_mem pins seen by mem_port_arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface mem_port_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        ack0;
    logic        ack1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        output ack0, ack1, rdata0, rdata1, mem_read, mem_write, mem_addr, mem_write_data
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        input  ack0, ack1, rdata0, rdata1, mem_read, mem_write, mem_addr, mem_write_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin two-port arbiter in front of a single async_mem; reads hold
// mem_read for READ_WAIT cycles before sampling, writes take one cycle.
module mem_port_arbiter #(
    parameter int READ_WAIT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus
);
    localparam int CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic            r_sel;
    logic            r_last;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata0;
    logic [31:0]     r_rdata1;
    logic            w_grant;
    logic            w_gsel;
    logic            w_gwe;
    logic            w_cnt_zero;
    logic            w_done;

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // On contention the port that was not served last wins.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_gsel       = 1'b0;
        w_gwe        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_grant      = 1'b1;
                    w_gsel       = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
                    w_gwe        = w_gsel ? bus.we1 : bus.we0;
                    w_state_next = w_gwe ? S_WR : S_RD;
                end
            end
            S_RD: begin
                if (w_cnt_zero) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WR:    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_done             = ((r_state == S_RD) && w_cnt_zero) || (r_state == S_WR);
        bus.mem_read       = (r_state == S_RD);
        bus.mem_write      = (r_state == S_WR);
        bus.ack0           = w_done && !r_sel;
        bus.ack1           = w_done && r_sel;
        bus.mem_addr       = r_addr;
        bus.mem_write_data = r_wdata;
        bus.rdata0         = r_rdata0;
        bus.rdata1         = r_rdata1;
    end

    // Access attributes are frozen at grant so requester changes mid-access are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_sel    <= 1'b0;
            r_last   <= 1'b1;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rdata0 <= 32'd0;
            r_rdata1 <= 32'd0;
        end else begin
            if (w_grant) begin
                r_sel   <= w_gsel;
                r_last  <= w_gsel;
                r_addr  <= w_gsel ? bus.addr1 : bus.addr0;
                r_wdata <= w_gsel ? bus.wdata1 : bus.wdata0;
                r_cnt   <= CW'(READ_WAIT - 1);
            end else if ((r_state == S_RD) && !w_cnt_zero) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if ((r_state == S_RD) && w_cnt_zero) begin
                if (r_sel) begin
                    r_rdata1 <= bus.mem_read_data;
                end else begin
                    r_rdata0 <= bus.mem_read_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: constant vector table, corner-case sequences,
// and random traffic checked against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int RW_A = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_init = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();
    mem_port_arbiter_if bus_b ();

    mem_port_arbiter #(.READ_WAIT(RW_A)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    mem_port_arbiter #(.READ_WAIT(1))    dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    function automatic logic [31:0] init_word(input int i);
        return (i == 5) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
    endfunction

    assign bus.mem_read_data   = mem_a[bus.mem_addr[9:2]];
    assign bus_b.mem_read_data = mem_b[bus_b.mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= init_word(i);
                mem_b[i] <= init_word(i);
            end
        end else begin
            if (bus.mem_write)   mem_a[bus.mem_addr[9:2]]   <= bus.mem_write_data;
            if (bus_b.mem_write) mem_b[bus_b.mem_addr[9:2]] <= bus_b.mem_write_data;
        end
    end

    typedef struct {
        bit          r0, r1, we0, we1;
        logic [31:0] a0, a1, d0, d1;
        int          lat0, lat1;
        logic [31:0] rd0, rd1;
    } vec_t;

    // Transaction-level reference state
    logic [31:0] m_mem [256];
    logic [31:0] m_rd [2];
    bit          m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Grant order follows the round-robin rule; each access costs its latency plus one idle cycle.
    task automatic model_vec(input vec_t vi, output vec_t vo);
        bit          rq [2];
        bit          wq [2];
        logic [31:0] aq [2];
        logic [31:0] dq [2];
        int          lat [2];
        int          order [2];
        int          n;
        int          t;
        int          p;
        vo = vi;
        rq[0] = vi.r0;  rq[1] = vi.r1;
        wq[0] = vi.we0; wq[1] = vi.we1;
        aq[0] = vi.a0;  aq[1] = vi.a1;
        dq[0] = vi.d0;  dq[1] = vi.d1;
        lat[0] = -1;    lat[1] = -1;
        order[0] = 0;   order[1] = 1;
        n = 0;
        t = 0;
        if (rq[0] && rq[1]) begin
            order[0] = m_last ? 0 : 1;
            order[1] = 1 - order[0];
            n = 2;
        end else if (rq[0]) begin
            order[0] = 0; n = 1;
        end else if (rq[1]) begin
            order[0] = 1; n = 1;
        end
        for (int k = 0; k < n; k++) begin
            p = order[k];
            t = t + (wq[p] ? 1 : RW_A);
            lat[p] = t;
            t = t + 1;
            if (wq[p]) m_mem[aq[p][9:2]] = dq[p];
            else       m_rd[p] = m_mem[aq[p][9:2]];
            m_last = (p == 1);
        end
        vo.lat0 = lat[0];
        vo.lat1 = lat[1];
        vo.rd0  = m_rd[0];
        vo.rd1  = m_rd[1];
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int c = 0;
        int got0 = -1;
        int got1 = -1;
        bit p0 = v.r0;
        bit p1 = v.r1;
        bus.req0 = v.r0; bus.we0 = v.we0; bus.addr0 = v.a0; bus.wdata0 = v.d0;
        bus.req1 = v.r1; bus.we1 = v.we1; bus.addr1 = v.a1; bus.wdata1 = v.d1;
        while ((p0 || p1) && c < 40) begin
            tick();
            c++;
            chk({tag, "_dual_ack"}, 32'(bus.ack0 & bus.ack1), 32'd0);
            if (bus.ack0) begin
                if (got0 < 0) begin
                    got0 = c;
                    if (v.r0) begin
                        chk({tag, "_addr0"}, bus.mem_addr, v.a0);
                        if (v.we0) begin
                            chk({tag, "_wdata0"}, bus.mem_write_data, v.d0);
                            chk({tag, "_mwrite0"}, 32'(bus.mem_write), 32'd1);
                        end else begin
                            chk({tag, "_mread0"}, 32'(bus.mem_read), 32'd1);
                        end
                    end
                    p0 = 1'b0;
                    bus.req0 = 1'b0;
                end else begin
                    chk({tag, "_extra_ack0"}, 32'(bus.ack0), 32'd0);
                end
            end
            if (bus.ack1) begin
                if (got1 < 0) begin
                    got1 = c;
                    if (v.r1) begin
                        chk({tag, "_addr1"}, bus.mem_addr, v.a1);
                        if (v.we1) begin
                            chk({tag, "_wdata1"}, bus.mem_write_data, v.d1);
                            chk({tag, "_mwrite1"}, 32'(bus.mem_write), 32'd1);
                        end else begin
                            chk({tag, "_mread1"}, 32'(bus.mem_read), 32'd1);
                        end
                    end
                    p1 = 1'b0;
                    bus.req1 = 1'b0;
                end else begin
                    chk({tag, "_extra_ack1"}, 32'(bus.ack1), 32'd0);
                end
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        chk({tag, "_lat0"}, 32'(got0), 32'(v.lat0));
        chk({tag, "_lat1"}, 32'(got1), 32'(v.lat1));
        chk({tag, "_rdata0"}, bus.rdata0, v.rd0);
        chk({tag, "_rdata1"}, bus.rdata1, v.rd1);
        $display("txn %s: r=%0d%0d we=%0d%0d ack_at=%0d/%0d rdata0=%h rdata1=%h",
                 tag, v.r0, v.r1, v.we0, v.we1, got0, got1, bus.rdata0, bus.rdata1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_last = 1'b1;
        m_rd[0] = 32'd0;
        m_rd[1] = 32'd0;
    endtask

    vec_t tbl [8];
    vec_t ve;
    vec_t vr;

    initial begin
        int          rd_cycles;
        logic [31:0] e0;
        logic [31:0] e1;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        bus_b.req0 = 0; bus_b.req1 = 0; bus_b.we0 = 0; bus_b.we1 = 0;
        bus_b.addr0 = 0; bus_b.addr1 = 0; bus_b.wdata0 = 0; bus_b.wdata1 = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = init_word(i);
        m_rd[0] = 32'd0; m_rd[1] = 32'd0; m_last = 1'b1;

        //            r0 r1 w0 w1  a0        a1        d0            d1            lat0 lat1 rd0           rd1
        tbl[0] = '{1, 0, 0, 0, 32'h14, 32'h0,  32'h0,        32'h0,        3,  -1, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{0, 1, 0, 1, 32'h0,  32'hC8, 32'h0,        32'h12345678, -1, 1,  32'hDEADBEEF, 32'h0};
        tbl[2] = '{0, 1, 0, 0, 32'h0,  32'hC8, 32'h0,        32'h0,        -1, 3,  32'hDEADBEEF, 32'h12345678};
        tbl[3] = '{1, 1, 0, 0, 32'h20, 32'h24, 32'h0,        32'h0,        3,  7,  32'hC0DE0008, 32'hC0DE0009};
        tbl[4] = '{1, 1, 1, 0, 32'h30, 32'h30, 32'hCAFEF00D, 32'h0,        1,  5,  32'hC0DE0008, 32'hCAFEF00D};
        tbl[5] = '{1, 1, 0, 1, 32'h30, 32'h34, 32'h0,        32'h0BADF00D, 3,  5,  32'hCAFEF00D, 32'hCAFEF00D};
        tbl[6] = '{1, 0, 0, 0, 32'h40, 32'h0,  32'h0,        32'h0,        3,  -1, 32'hC0DE0010, 32'hCAFEF00D};
        tbl[7] = '{1, 1, 0, 0, 32'h44, 32'h48, 32'h0,        32'h0,        7,  3,  32'hC0DE0011, 32'hC0DE0012};

        repeat (3) @(negedge clk);
        chk("rst_ack0", 32'(bus.ack0), 32'd0);
        chk("rst_ack1", 32'(bus.ack1), 32'd0);
        chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_rdata0", bus.rdata0, 32'd0);
        chk("rst_rdata1", bus.rdata1, 32'd0);
        mem_init = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            model_vec(tbl[i], ve);
            run_vec(tbl[i], $sformatf("tbl%0d", i));
            if (i == 1) chk("tbl1_mem50", mem_a[50], 32'h12345678);
        end

        // Continuous contention: grants alternate 0,1,0,1 with one idle cycle between
        do_reset();
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h50;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h54;
        for (int c = 1; c <= 16; c++) begin
            tick();
            e0 = (c == 3 || c == 11) ? 32'd1 : 32'd0;
            e1 = (c == 7 || c == 15) ? 32'd1 : 32'd0;
            chk($sformatf("rr_ack0_c%0d", c), 32'(bus.ack0), e0);
            chk($sformatf("rr_ack1_c%0d", c), 32'(bus.ack1), e1);
            if (c == 8) chk("rr_rdata0_mid", bus.rdata0, m_mem[20]);
            if (c == 15) begin
                bus.req0 = 0;
                bus.req1 = 0;
            end
        end
        chk("rr_rdata0", bus.rdata0, m_mem[20]);
        chk("rr_rdata1", bus.rdata1, m_mem[21]);
        m_rd[0] = m_mem[20]; m_rd[1] = m_mem[21]; m_last = 1'b1;
        $display("txn rr: 4 contended reads rdata0=%h rdata1=%h", bus.rdata0, bus.rdata1);

        // Reset during the second read-wait cycle abandons the access
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h14;
        tick();
        tick();
        chk("rstmid_noack_c2", 32'(bus.ack0), 32'd0);
        reset = 1'b1;
        bus.req0 = 0;
        tick();
        chk("rstmid_mem_read", 32'(bus.mem_read), 32'd0);
        chk("rstmid_ack0", 32'(bus.ack0), 32'd0);
        chk("rstmid_rdata0", bus.rdata0, 32'd0);
        reset = 1'b0;
        m_last = 1'b1; m_rd[0] = 32'd0; m_rd[1] = 32'd0;
        $display("txn rstmid: access abandoned rdata0=%h", bus.rdata0);
        vr = '{1, 0, 0, 0, 32'h14, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0};
        model_vec(vr, ve);
        run_vec(ve, "after_rst");

        // Write then read the same address from port 0, back to back
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 32'h60; bus.wdata0 = 32'h600DCAFE;
        tick();
        chk("b2b_wr_ack", 32'(bus.ack0), 32'd1);
        chk("b2b_wr_mwrite", 32'(bus.mem_write), 32'd1);
        bus.we0 = 0;
        tick();
        chk("b2b_bubble_ack", 32'(bus.ack0), 32'd0);
        chk("b2b_bubble_rw", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        rd_cycles = 0;
        for (int c = 3; c <= 5; c++) begin
            tick();
            rd_cycles += int'(bus.mem_read);
            if (c < 5) chk($sformatf("b2b_noack_c%0d", c), 32'(bus.ack0), 32'd0);
        end
        chk("b2b_rd_ack", 32'(bus.ack0), 32'd1);
        chk("b2b_rd_cycles", 32'(rd_cycles), 32'd3);
        bus.req0 = 0;
        tick();
        chk("b2b_rdata0", bus.rdata0, 32'h600DCAFE);
        m_mem[24] = 32'h600DCAFE; m_rd[0] = 32'h600DCAFE; m_last = 1'b0;
        $display("txn b2b: write+read 0x60 rdata0=%h", bus.rdata0);

        // READ_WAIT=1 instance: ack one cycle after grant, address frozen
        bus_b.req0 = 1; bus_b.we0 = 0; bus_b.addr0 = 32'h14;
        tick();
        bus_b.addr0 = 32'h18;
        #1;
        chk("rw1_ack0", 32'(bus_b.ack0), 32'd1);
        chk("rw1_mem_read", 32'(bus_b.mem_read), 32'd1);
        chk("rw1_mem_addr", bus_b.mem_addr, 32'h14);
        bus_b.req0 = 0;
        tick();
        chk("rw1_rdata0", bus_b.rdata0, 32'hDEADBEEF);
        chk("rw1_idle", 32'({bus_b.mem_read, bus_b.ack0}), 32'd0);
        $display("txn rw1: read 0x14 rdata0=%h", bus_b.rdata0);

        for (int i = 0; i < 40; i++) begin
            vr.r0  = 1'($urandom_range(0, 1));
            vr.r1  = vr.r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            vr.we0 = 1'($urandom_range(0, 1));
            vr.we1 = 1'($urandom_range(0, 1));
            vr.a0  = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 7)) << 2);
            vr.a1  = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 7)) << 2);
            vr.d0  = $urandom;
            vr.d1  = $urandom;
            vr.lat0 = 0; vr.lat1 = 0; vr.rd0 = 0; vr.rd1 = 0;
            model_vec(vr, ve);
            run_vec(ve, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
